mem_lsu_mc: RTL

- Multi-cycle load/store unit replacing the combinational memory-access stage of the pipeline.
- Accepts one access per request from the EX/MEM register and drives a request/acknowledge data-bus handshake.
- Holds the pipeline through stall_req_o until the bus answers, then returns the aligned, sign- or zero-extended load result with the destination register tag.
- Generalises the stage to 32/64-bit data paths, variable-latency memory, alignment exceptions and flush handling.

---
 rtl/mem_lsu_mc_pkg.sv | 69 ++++++
 rtl/mem_lsu_mc_align.sv | 48 ++++
 rtl/mem_lsu_mc.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/mem_lsu_mc_pkg.sv
// Shared definitions for the multi-cycle load/store unit: op codes, FSM states,
// and helpers for op decoding, alignment checks and big-endian lane indexing.
package mem_lsu_mc_pkg;

    localparam logic [3:0] OP_LB  = 4'd0;
    localparam logic [3:0] OP_LBU = 4'd1;
    localparam logic [3:0] OP_LH  = 4'd2;
    localparam logic [3:0] OP_LHU = 4'd3;
    localparam logic [3:0] OP_LW  = 4'd4;
    localparam logic [3:0] OP_LWU = 4'd5;
    localparam logic [3:0] OP_LD  = 4'd6;
    localparam logic [3:0] OP_SB  = 4'd7;
    localparam logic [3:0] OP_SH  = 4'd8;
    localparam logic [3:0] OP_SW  = 4'd9;
    localparam logic [3:0] OP_SD  = 4'd10;
    localparam logic [3:0] OP_LL  = 4'd11;
    localparam logic [3:0] OP_SC  = 4'd12;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    // log2 of the access size in bytes
    function automatic logic [1:0] op_size(input logic [3:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB:                  return 2'd0;
            OP_LH, OP_LHU, OP_SH:                  return 2'd1;
            OP_LW, OP_LWU, OP_SW, OP_LL, OP_SC:    return 2'd2;
            default:                               return 2'd3;
        endcase
    endfunction

    function automatic logic op_is_store(input logic [3:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW) ||
               (op == OP_SD) || (op == OP_SC);
    endfunction

    function automatic logic op_is_signed(input logic [3:0] op);
        return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) || (op == OP_LL);
    endfunction

    // LWU/LD/SD only exist on a 64-bit data path; codes above SC are never legal
    function automatic logic op_legal(input logic [3:0] op, input logic wide);
        case (op)
            OP_LWU, OP_LD, OP_SD: return wide;
            OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW,
            OP_SB, OP_SH, OP_SW, OP_LL, OP_SC: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic is_aligned(input logic [1:0] size, input logic [2:0] a);
        case (size)
            2'd0:    return 1'b1;
            2'd1:    return a[0] == 1'b0;
            2'd2:    return a[1:0] == 2'b00;
            default: return a[2:0] == 3'b000;
        endcase
    endfunction

    // byte at address offset k lives in lane bit NB-1-k (offset 0 is the MSB lane)
    function automatic int lane_bit(input int nb, input int k);
        return nb - 1 - k;
    endfunction

endpackage

// File: rtl/mem_lsu_mc_align.sv
// Combinational lane-select, store-replicate and load-extend unit for the LSU.
module mem_lsu_align
    import mem_lsu_mc_pkg::*;
#(
    parameter int DATA_W = 32,
    localparam int NB = DATA_W / 8,
    localparam int OFFW = $clog2(NB)
) (
    input  logic [3:0]        op,
    input  logic [OFFW-1:0]   off,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] rdata,
    output logic [NB-1:0]     sel,
    output logic [DATA_W-1:0] wdata_rep,
    output logic [DATA_W-1:0] rdata_ext
);

    logic [1:0]        size;
    int                nbytes;
    int                lo;
    logic [DATA_W-1:0] fmask;
    logic [DATA_W-1:0] field;
    logic              msb;

    always_comb begin
        size   = op_size(op);
        nbytes = 32'd1 << size;
        // lowest lane bit touched by the access; the run extends nbytes lanes upward
        lo = lane_bit(NB, int'(off) + nbytes - 1);
        if (lo < 0) lo = 0;
        sel = NB'((32'd1 << nbytes) - 32'd1) << lo;

        if (nbytes * 8 >= DATA_W) fmask = '1;
        else                      fmask = (DATA_W'(1) << (nbytes * 8)) - DATA_W'(1);
        field     = rdata >> (lo * 8);
        msb       = |(field & (fmask ^ (fmask >> 1)));
        rdata_ext = field & fmask;
        if (op_is_signed(op) && msb) rdata_ext = rdata_ext | ~fmask;

        case (size)
            2'd0:    wdata_rep = {NB{wdata[7:0]}};
            2'd1:    wdata_rep = {(NB/2){wdata[15:0]}};
            2'd2:    wdata_rep = {(NB/4){wdata[31:0]}};
            default: wdata_rep = wdata;
        endcase
    end

endmodule

// File: rtl/mem_lsu_mc.sv
// Multi-cycle load/store unit with a req/ack data bus. Define MEM_LSU_LLSC_EN to
// enable the link bit and LL/SC semantics; otherwise LL acts as LW and SC as SW.
module mem_lsu_mc
    import mem_lsu_mc_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    localparam int NB = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_i,
    input  logic [3:0]        op_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [4:0]        wd_i,
    input  logic              flush_i,
    input  logic              llclr_i,
    output logic              bus_req_o,
    output logic              bus_we_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [NB-1:0]     bus_sel_o,
    output logic [DATA_W-1:0] bus_wdata_o,
    input  logic              bus_ack_i,
    input  logic [DATA_W-1:0] bus_rdata_i,
    output logic              stall_req_o,
    output logic              done_o,
    output logic [4:0]        wd_o,
    output logic              wreg_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              adel_o,
    output logic              ades_o,
    output logic              llbit_o
);

    localparam int OFFW = $clog2(NB);

    state_t            state;
    logic [3:0]        op_q;
    logic [OFFW-1:0]   off_q;
    logic              kill;
    logic              done_r;
    logic              wreg_r;

    logic              legal;
    logic              aligned;
    logic              accept;
    logic              sc_fail;
    logic [3:0]        cur_op;
    logic [OFFW-1:0]   cur_off;
    logic [NB-1:0]     sel;
    logic [DATA_W-1:0] wrep;
    logic [DATA_W-1:0] rext;

    assign legal   = op_legal(op_i, DATA_W == 64);
    assign aligned = is_aligned(op_size(op_i), addr_i[2:0]);
    assign accept  = req_valid_i & ~flush_i & legal;

    // the aligner sees the incoming op while idle and the latched op afterwards
    assign cur_op  = (state == ST_IDLE) ? op_i : op_q;
    assign cur_off = (state == ST_IDLE) ? addr_i[OFFW-1:0] : off_q;

    mem_lsu_align #(.DATA_W(DATA_W)) u_align (
        .op        (cur_op),
        .off       (cur_off),
        .wdata     (wdata_i),
        .rdata     (bus_rdata_i),
        .sel       (sel),
        .wdata_rep (wrep),
        .rdata_ext (rext)
    );

`ifdef MEM_LSU_LLSC_EN
    logic link;
    assign sc_fail = (op_i == OP_SC) & ~link;
    assign llbit_o = link;
`else
    logic llclr_unused;
    assign llclr_unused = llclr_i;
    assign sc_fail      = 1'b0;
    assign llbit_o      = 1'b0;
`endif

    assign stall_req_o = ((state == ST_IDLE) & accept) | (state == ST_BUS) | (state == ST_ERR);
    assign done_o      = done_r & ~flush_i;
    assign wreg_o      = wreg_r & ~flush_i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            op_q        <= '0;
            off_q       <= '0;
            kill        <= 1'b0;
            done_r      <= 1'b0;
            wreg_r      <= 1'b0;
            wd_o        <= '0;
            rdata_o     <= '0;
            adel_o      <= 1'b0;
            ades_o      <= 1'b0;
            bus_req_o   <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_addr_o  <= '0;
            bus_sel_o   <= '0;
            bus_wdata_o <= '0;
`ifdef MEM_LSU_LLSC_EN
            link        <= 1'b0;
`endif
        end else begin
            done_r <= 1'b0;
            wreg_r <= 1'b0;
            adel_o <= 1'b0;
            ades_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        op_q  <= op_i;
                        off_q <= addr_i[OFFW-1:0];
                        wd_o  <= wd_i;
                        kill  <= 1'b0;
                        if (!aligned) begin
                            state  <= ST_ERR;
                            adel_o <= ~op_is_store(op_i);
                            ades_o <= op_is_store(op_i);
                        end else if (sc_fail) begin
                            // SC without a link completes immediately, no bus access
                            state   <= ST_DONE;
                            done_r  <= 1'b1;
                            wreg_r  <= 1'b1;
                            rdata_o <= '0;
                        end else begin
                            state       <= ST_BUS;
                            bus_req_o   <= 1'b1;
                            bus_we_o    <= op_is_store(op_i);
                            bus_addr_o  <= {addr_i[ADDR_W-1:OFFW], {OFFW{1'b0}}};
                            bus_sel_o   <= sel;
                            bus_wdata_o <= op_is_store(op_i) ? wrep : '0;
                        end
                    end
                end
                ST_BUS: begin
                    if (flush_i) kill <= 1'b1;
                    if (bus_ack_i) begin
                        bus_req_o <= 1'b0;
                        state     <= ST_DONE;
                        if (op_is_store(op_q)) rdata_o <= (op_q == OP_SC) ? DATA_W'(1) : '0;
                        else                   rdata_o <= rext;
                        // a flush seen at any point of the bus phase retires the op silently
                        if (!(kill || flush_i)) begin
                            done_r <= 1'b1;
                            wreg_r <= ~op_is_store(op_q) | (op_q == OP_SC);
`ifdef MEM_LSU_LLSC_EN
                            if (op_q == OP_LL) link <= 1'b1;
                            if (op_q == OP_SC) link <= 1'b0;
`endif
                        end
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
`ifdef MEM_LSU_LLSC_EN
            if (llclr_i) link <= 1'b0;
`endif
        end
    end

endmodule
